game_input_conditioner: RTL and testbench
=========================================

// Module: game_input_conditioner
// PURPOSE
//   Front-end stage between raw board inputs and the match-stick game FSM.
//   - Synchronises and debounces the two pushbuttons and the 4 dip switches.
//   - Turns presses into single-cycle strobes.
//   - Packages a confirm press with the stable switch value into a move
//     strobe with a legality flag.
//   - The game FSM consumes the strobes instead of sampling raw, bouncing
//     levels every clock.
// PARAMETERS
//   DEBOUNCE_CYCLES  65536  consecutive cycles an input must differ from its filtered value to be accepted (>=2)
//   CNT_W            17     debounce counter width; must hold DEBOUNCE_CYCLES-1
//   MOVE_MIN         1      smallest legal move value
//   MOVE_MAX         10     largest legal move value
// PORTS
//   clk           in   1  system clock, all logic on posedge
//   rst           in   1  synchronous active-high reset
//   pushbuttons   in   2  raw buttons, active high; [0]=confirm move, [1]=restart
//   dipswitches   in   4  raw switches, move value
//   btn_level     out  2  debounced button levels
//   btn_press     out  2  one-cycle strobe per debounced 0->1 edge (armed buttons only)
//   move_valid    out  1  one-cycle strobe: confirm accepted
//   move_value    out  4  filtered switch value captured at move_valid; held until next move
//   move_legal    out  1  MOVE_MIN<=move_value<=MOVE_MAX; valid with and held alongside move_value
//   restart       out  1  one-cycle strobe: restart accepted
// BEHAVIOUR
//   Reset:
//   - Every output, synchroniser flop, counter, filtered value and arm flag is 0.
//   Synchroniser:
//   - Each of the 6 raw bits passes through 2 flops (s1, s2).
//   Button filter (per button):
//   - If s2 == level, cnt <= 0.
//   - Otherwise cnt increments.
//   - On the cycle cnt == DEBOUNCE_CYCLES-1 with s2 still differing: level <= s2 and cnt <= 0.
//   - A single s2 glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
//   - Latency from raw edge to btn_level change: DEBOUNCE_CYCLES+2 cycles.
//   Switch filter:
//   - One shared counter for the 4-bit vector, compared against sw_stable.
//   - Any s2 change of the vector's value restarts the count from 0.
//   - sw_stable updates after DEBOUNCE_CYCLES consecutive cycles of an unchanged differing value.
//   Arm flags (per button):
//   - Set when btn_level is 0; cleared by rst.
//   - A button held through reset gives no press until released (debounced) and pressed again.
//   btn_press:
//   - Registered; high in exactly the first cycle btn_level reads 1, if that button was armed.
//   - Never high on two consecutive cycles.
//   restart:
//   - Equals btn_press[1].
//   move_valid:
//   - Equals btn_press[0], gated off when btn_press[1] is high or btn_level[1] is 1.
//   - Restart has priority, including simultaneous presses.
//   - On move_valid, move_value <= sw_stable and move_legal <= range check, in the same cycle.
//   - The 4-bit compare is unsigned; values 0 and 11..15 are illegal but still reported with move_valid.
//   Switch change during a held confirm:
//   - Has no effect on move_value until the next move_valid.
//   Reset mid-debounce:
//   - Discards partial counts.
//   - The first press after reset needs a full DEBOUNCE_CYCLES window.
//   Counters:
//   - Never wrap; they clear or saturate at DEBOUNCE_CYCLES-1 as above.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Raw pushbuttons[0] 0->1, held 20 cycles, switches=4'd3 stable ->
//      btn_level[0] rises 6 cycles after the edge; move_valid=1 for 1 cycle,
//      move_value=3, move_legal=1.
//   2. pushbuttons[0] bounce 1,0,1,0 (1 cycle each), then held high ->
//      exactly one move_valid, issued 6 cycles after the final rising edge.
//   3. switches=4'd0, then 4'd11, then 4'd10, each confirmed ->
//      move_legal = 0, 0, 1; move_valid fires every time.
//   4. Both buttons rise in the same cycle ->
//      restart=1, move_valid=0.
//      Confirm pressed while restart is held -> no move_valid.
//   5. Button[0] held across rst pulse ->
//      no strobe until release plus re-press; then exactly one move_valid.
//   6. Switch changes 4'd5->4'd7 while confirm is held after a move ->
//      move_value stays 5 until the next confirm press, then reads 7.

Source files
------------

// File: rtl/game_input_conditioner.sv
// rtl/game_input_conditioner.sv - synchronise/debounce buttons and switches into move and restart strobes
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = 17,
    parameter int MOVE_MIN        = 1,
    parameter int MOVE_MAX        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pushbuttons,
    input  logic [3:0] dipswitches,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press,
    output logic       move_valid,
    output logic [3:0] move_value,
    output logic       move_legal,
    output logic       restart
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       MIN4     = 4'(MOVE_MIN);
    localparam logic [3:0]       MAX4     = 4'(MOVE_MAX);

    logic [1:0]       btn_s1, btn_s2;
    logic [3:0]       sw_s1, sw_s2, sw_last, sw_stable;
    logic [CNT_W-1:0] btn_cnt [2];
    logic [CNT_W-1:0] sw_cnt;
    logic [1:0]       arm;
    logic [1:0]       sync_rdy;

    logic [1:0]       btn_fire;
    logic [1:0]       level_next;
    logic [1:0]       press_next;
    logic             move_next;
    logic             sw_legal;

    always_comb begin
        btn_fire   = '0;
        level_next = btn_level;
        press_next = '0;
        for (int i = 0; i < 2; i++) begin
            btn_fire[i]   = (btn_s2[i] != btn_level[i]) && (btn_cnt[i] == CNT_LAST);
            level_next[i] = btn_fire[i] ? btn_s2[i] : btn_level[i];
            press_next[i] = btn_fire[i] && btn_s2[i] && arm[i];
        end
        // Restart wins: any confirm while restart is pressed or held is dropped.
        move_next = press_next[0] && !level_next[1];
        sw_legal  = (sw_stable >= MIN4) && (sw_stable <= MAX4);
    end

    assign restart = btn_press[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            sw_last    <= '0;
            sw_stable  <= '0;
            btn_cnt[0] <= '0;
            btn_cnt[1] <= '0;
            sw_cnt     <= '0;
            arm        <= '0;
            sync_rdy   <= '0;
            btn_level  <= '0;
            btn_press  <= '0;
            move_valid <= 1'b0;
            move_value <= '0;
            move_legal <= 1'b0;
        end else begin
            btn_s1   <= pushbuttons;
            btn_s2   <= btn_s1;
            sw_s1    <= dipswitches;
            sw_s2    <= sw_s1;
            sync_rdy <= {sync_rdy[0], 1'b1};

            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_level[i] || btn_fire[i])
                    btn_cnt[i] <= '0;
                else
                    btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
                // Arming waits for the synchroniser to refill so a button held
                // through reset is seen as released only once it really is.
                if (sync_rdy[1] && !btn_level[i] && !btn_s2[i])
                    arm[i] <= 1'b1;
            end

            btn_level  <= level_next;
            btn_press  <= press_next;
            move_valid <= move_next;
            if (move_next) begin
                move_value <= sw_stable;
                move_legal <= sw_legal;
            end

            sw_last <= sw_s2;
            if (sw_s2 == sw_stable) begin
                sw_cnt <= '0;
            end else if (sw_s2 != sw_last) begin
                sw_cnt <= CNT_ONE;
            end else if (sw_cnt == CNT_LAST) begin
                sw_stable <= sw_s2;
                sw_cnt    <= '0;
            end else begin
                sw_cnt <= sw_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_game_input_conditioner.sv
// tb/tb_game_input_conditioner.sv - directed bench for game_input_conditioner with DEBOUNCE_CYCLES=4
module tb_game_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pushbuttons;
    logic [3:0] dipswitches;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic       move_valid;
    logic [3:0] move_value;
    logic       move_legal;
    logic       restart;

    int vec = 0;
    int err = 0;
    int mv_cnt = 0;
    int rs_cnt = 0;
    int base_mv, base_rs;

    logic [3:0] sw_tab    [3] = '{4'd0, 4'd11, 4'd10};
    logic       legal_tab [3] = '{1'b0, 1'b0, 1'b1};

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .MOVE_MIN(1),
        .MOVE_MAX(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pushbuttons(pushbuttons),
        .dipswitches(dipswitches),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .move_valid(move_valid),
        .move_value(move_value),
        .move_legal(move_legal),
        .restart(restart)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (move_valid) mv_cnt++;
        if (restart) rs_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; pushbuttons = 2'b00; dipswitches = 4'd0;
        step(3);
        vec++; if (btn_level !== 2'b00) begin err++; $display("FAIL reset_level: got %b want 00", btn_level); end
        vec++; if (btn_press !== 2'b00) begin err++; $display("FAIL reset_press: got %b want 00", btn_press); end
        vec++; if (move_valid !== 1'b0) begin err++; $display("FAIL reset_mv: got %b want 0", move_valid); end
        vec++; if (move_value !== 4'd0) begin err++; $display("FAIL reset_value: got %0d want 0", move_value); end
        vec++; if (move_legal !== 1'b0) begin err++; $display("FAIL reset_legal: got %b want 0", move_legal); end
        vec++; if (restart !== 1'b0) begin err++; $display("FAIL reset_restart: got %b want 0", restart); end
        rst = 1'b0;
        step(6);
    endtask

    task automatic test_clean_press;
        dipswitches = 4'd3;
        step(8);
        base_mv = mv_cnt;
        pushbuttons = 2'b01;
        step(5);
        vec++; if (btn_level[0] !== 1'b0) begin err++; $display("FAIL clean_early_level: got %b want 0", btn_level[0]); end
        step(1);
        vec++; if (btn_level[0] !== 1'b1) begin err++; $display("FAIL clean_level: got %b want 1", btn_level[0]); end
        vec++; if (btn_press !== 2'b01) begin err++; $display("FAIL clean_press: got %b want 01", btn_press); end
        vec++; if (move_valid !== 1'b1) begin err++; $display("FAIL clean_mv: got %b want 1", move_valid); end
        vec++; if (move_value !== 4'd3) begin err++; $display("FAIL clean_value: got %0d want 3", move_value); end
        vec++; if (move_legal !== 1'b1) begin err++; $display("FAIL clean_legal: got %b want 1", move_legal); end
        step(1);
        vec++; if (move_valid !== 1'b0) begin err++; $display("FAIL clean_mv_drop: got %b want 0", move_valid); end
        vec++; if (btn_press !== 2'b00) begin err++; $display("FAIL clean_press_drop: got %b want 00", btn_press); end
        step(13);
        vec++; if (mv_cnt - base_mv !== 1) begin err++; $display("FAIL clean_count: got %0d want 1", mv_cnt - base_mv); end
        pushbuttons = 2'b00;
        step(10);
        vec++; if (btn_level !== 2'b00) begin err++; $display("FAIL clean_release: got %b want 00", btn_level); end
    endtask

    task automatic test_bounce;
        base_mv = mv_cnt;
        pushbuttons = 2'b01; step(1);
        pushbuttons = 2'b00; step(1);
        pushbuttons = 2'b01; step(1);
        pushbuttons = 2'b00; step(1);
        pushbuttons = 2'b01;
        step(5);
        vec++; if (mv_cnt - base_mv !== 0) begin err++; $display("FAIL bounce_early: got %0d want 0", mv_cnt - base_mv); end
        vec++; if (btn_level[0] !== 1'b0) begin err++; $display("FAIL bounce_level_early: got %b want 0", btn_level[0]); end
        step(1);
        vec++; if (move_valid !== 1'b1) begin err++; $display("FAIL bounce_mv: got %b want 1", move_valid); end
        step(14);
        vec++; if (mv_cnt - base_mv !== 1) begin err++; $display("FAIL bounce_count: got %0d want 1", mv_cnt - base_mv); end
        pushbuttons = 2'b00;
        step(10);
    endtask

    task automatic test_legality;
        for (int i = 0; i < 3; i++) begin
            dipswitches = sw_tab[i];
            step(8);
            pushbuttons = 2'b01;
            step(6);
            vec++; if (move_valid !== 1'b1) begin err++; $display("FAIL legal_mv[%0d]: got %b want 1", i, move_valid); end
            vec++; if (move_value !== sw_tab[i]) begin err++; $display("FAIL legal_value[%0d]: got %0d want %0d", i, move_value, sw_tab[i]); end
            vec++; if (move_legal !== legal_tab[i]) begin err++; $display("FAIL legal_flag[%0d]: got %b want %b", i, move_legal, legal_tab[i]); end
            pushbuttons = 2'b00;
            step(10);
        end
    endtask

    task automatic test_simultaneous;
        base_mv = mv_cnt; base_rs = rs_cnt;
        pushbuttons = 2'b11;
        step(6);
        vec++; if (restart !== 1'b1) begin err++; $display("FAIL simul_restart: got %b want 1", restart); end
        vec++; if (move_valid !== 1'b0) begin err++; $display("FAIL simul_mv: got %b want 0", move_valid); end
        vec++; if (btn_press !== 2'b11) begin err++; $display("FAIL simul_press: got %b want 11", btn_press); end
        step(1);
        vec++; if (restart !== 1'b0) begin err++; $display("FAIL simul_restart_drop: got %b want 0", restart); end
        pushbuttons = 2'b10;
        step(10);
        pushbuttons = 2'b11;
        step(12);
        vec++; if (mv_cnt - base_mv !== 0) begin err++; $display("FAIL held_restart_mv: got %0d want 0", mv_cnt - base_mv); end
        vec++; if (rs_cnt - base_rs !== 1) begin err++; $display("FAIL held_restart_count: got %0d want 1", rs_cnt - base_rs); end
        pushbuttons = 2'b00;
        step(10);
    endtask

    task automatic test_reset_held;
        pushbuttons = 2'b01;
        step(10);
        rst = 1'b1;
        step(2);
        vec++; if (btn_level !== 2'b00) begin err++; $display("FAIL held_rst_level: got %b want 00", btn_level); end
        rst = 1'b0;
        base_mv = mv_cnt;
        step(15);
        vec++; if (btn_level[0] !== 1'b1) begin err++; $display("FAIL held_level_follow: got %b want 1", btn_level[0]); end
        vec++; if (mv_cnt - base_mv !== 0) begin err++; $display("FAIL held_no_strobe: got %0d want 0", mv_cnt - base_mv); end
        pushbuttons = 2'b00;
        step(10);
        vec++; if (btn_level[0] !== 1'b0) begin err++; $display("FAIL held_release: got %b want 0", btn_level[0]); end
        pushbuttons = 2'b01;
        step(6);
        vec++; if (move_valid !== 1'b1) begin err++; $display("FAIL held_repress_mv: got %b want 1", move_valid); end
        step(10);
        vec++; if (mv_cnt - base_mv !== 1) begin err++; $display("FAIL held_repress_count: got %0d want 1", mv_cnt - base_mv); end
        pushbuttons = 2'b00;
        step(10);
    endtask

    task automatic test_switch_hold;
        dipswitches = 4'd5;
        step(8);
        pushbuttons = 2'b01;
        step(8);
        vec++; if (move_value !== 4'd5) begin err++; $display("FAIL sw_first: got %0d want 5", move_value); end
        dipswitches = 4'd7;
        step(10);
        vec++; if (move_value !== 4'd5) begin err++; $display("FAIL sw_held: got %0d want 5", move_value); end
        pushbuttons = 2'b00;
        step(10);
        vec++; if (move_value !== 4'd5) begin err++; $display("FAIL sw_released: got %0d want 5", move_value); end
        pushbuttons = 2'b01;
        step(6);
        vec++; if (move_valid !== 1'b1) begin err++; $display("FAIL sw_next_mv: got %b want 1", move_valid); end
        vec++; if (move_value !== 4'd7) begin err++; $display("FAIL sw_next_value: got %0d want 7", move_value); end
        vec++; if (move_legal !== 1'b1) begin err++; $display("FAIL sw_next_legal: got %b want 1", move_legal); end
        pushbuttons = 2'b00;
        step(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_legality();
        test_simultaneous();
        test_reset_held();
        test_switch_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
